// File: rtl/hc595_ctrl.sv
// Serialises one parallel word per valid/ready handshake into a chain of 74HC595 devices.
// Optional build macro HC595_LSB_FIRST_EN: shift bit 0 first instead of bit NB-1.
module hc595_ctrl #(
    parameter int CHAIN   = 1,
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*CHAIN-1:0]   in_data,
    output logic                 ds,
    output logic                 shcp,
    output logic                 stcp,
    output logic                 oe_n,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           fsm_state
);

    localparam int NB = 8 * CHAIN;
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(NB + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_FULL = BW'(NB);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SH_LO = 3'd1,
        SH_HI = 3'd2,
        LATCH = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t          state, state_next;
    logic [DW-1:0]   div_cnt, div_next;
    logic [BW-1:0]   bit_cnt, bit_next;
    logic [NB-1:0]   shreg, shreg_next, shreg_shifted;
    logic            first_bit;

`ifdef HC595_LSB_FIRST_EN
    assign shreg_shifted = {1'b0, shreg[NB-1:1]};
    assign first_bit     = shreg_next[0];
`else
    assign shreg_shifted = {shreg[NB-2:0], 1'b0};
    assign first_bit     = shreg_next[NB-1];
`endif

    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        shreg_next = shreg;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = SH_LO;
                    div_next   = '0;
                    bit_next   = BIT_FULL;
                    shreg_next = in_data;
                end
            end
            SH_LO: begin
                if (div_cnt == DIV_LAST) begin
                    div_next   = '0;
                    state_next = SH_HI;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            SH_HI: begin
                if (div_cnt == DIV_LAST) begin
                    div_next   = '0;
                    shreg_next = shreg_shifted;
                    bit_next   = bit_cnt - 1'b1;
                    state_next = (bit_cnt == BIT_ONE) ? LATCH : SH_LO;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            LATCH: begin
                if (div_cnt == DIV_LAST) begin
                    div_next   = '0;
                    state_next = FIN;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pin outputs are registered from the next state so the pins never glitch on decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            in_ready <= 1'b1;
            ds       <= 1'b0;
            shcp     <= 1'b0;
            stcp     <= 1'b0;
            done     <= 1'b0;
            oe_n     <= 1'b1;
        end else begin
            state    <= state_next;
            div_cnt  <= div_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            in_ready <= (state_next == IDLE);
            ds       <= ((state_next == SH_LO) || (state_next == SH_HI)) ? first_bit : 1'b0;
            shcp     <= (state_next == SH_HI);
            stcp     <= (state_next == LATCH);
            done     <= (state_next == FIN);
            if (state == FIN) begin
                oe_n <= 1'b0;
            end
        end
    end

    assign busy      = ~in_ready;
    assign fsm_state = state;

endmodule

// File: tb/tb_hc595_ctrl.sv
// Bench for hc595_ctrl: two instances (CHAIN=1/CLK_DIV=2 and CHAIN=2/CLK_DIV=1) each driving a 595 chain model.
module tb_hc595_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- instance A: CHAIN=1, CLK_DIV=2 ----------------
    logic       rst_a = 1'b1, in_valid_a = 1'b0, in_ready_a, ds_a, shcp_a, stcp_a, oe_n_a, busy_a, done_a;
    logic [7:0] in_data_a = '0;
    logic [2:0] st_a;

    hc595_ctrl #(.CHAIN(1), .CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .ds(ds_a), .shcp(shcp_a), .stcp(stcp_a), .oe_n(oe_n_a), .busy(busy_a), .done(done_a),
        .fsm_state(st_a));

    // ---------------- instance B: CHAIN=2, CLK_DIV=1 ----------------
    logic        rst_b = 1'b1, in_valid_b = 1'b0, in_ready_b, ds_b, shcp_b, stcp_b, oe_n_b, busy_b, done_b;
    logic [15:0] in_data_b = '0;
    logic [2:0]  st_b;

    hc595_ctrl #(.CHAIN(2), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .ds(ds_b), .shcp(shcp_b), .stcp(stcp_b), .oe_n(oe_n_b), .busy(busy_b), .done(done_b),
        .fsm_state(st_b));

    // Scoreboards: expected ds bits at each shcp rise, expected latched word at each done.
    logic        bits_a[$];
    logic        bits_b[$];
    logic [15:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];

    // 595 chain models (device 1 = low byte, device n = high byte).
    logic [7:0]  sr_a = '0, stor_a = '0;
    logic [15:0] sr_b = '0, stor_b = '0;
    int          rises_a = 0, rises_b = 0;

    function automatic logic [15:0] exp_latch(input logic [15:0] w, input int nb);
        logic [15:0] r;
        r = w;
`ifdef HC595_LSB_FIRST_EN
        r = '0;
        for (int i = 0; i < nb; i++) r[nb-1-i] = w[i];
`endif
        return r;
    endfunction

    task automatic push_bits(input logic [15:0] w, input int nb, input bit to_b);
        logic b;
        for (int i = 0; i < nb; i++) begin
`ifdef HC595_LSB_FIRST_EN
            b = w[i];
`else
            b = w[nb-1-i];
`endif
            if (to_b) bits_b.push_back(b);
            else      bits_a.push_back(b);
        end
    endtask

    // Monitors sample on the falling edge, away from the DUT's active edge.
    initial begin
        logic prev_sh, prev_st;
        prev_sh = 1'b0;
        prev_st = 1'b0;
        forever begin
            @(negedge clk);
            if (shcp_a && !prev_sh) begin
                if (bits_a.size() == 0) check("a_extra_shcp", 1, 0);
                else check("a_ds", ds_a, bits_a.pop_front());
                sr_a = {sr_a[6:0], ds_a};
                rises_a++;
            end
            if (stcp_a && !prev_st) stor_a = sr_a;
            if (done_a) begin
                if (exp_q_a.size() == 0) check("a_extra_done", 1, 0);
                else check("a_latch", stor_a, exp_q_a.pop_front());
                check("a_shcp_count", rises_a, 8);
                rises_a = 0;
            end
            prev_sh = shcp_a;
            prev_st = stcp_a;
        end
    end

    initial begin
        logic prev_sh, prev_st;
        prev_sh = 1'b0;
        prev_st = 1'b0;
        forever begin
            @(negedge clk);
            if (shcp_b && !prev_sh) begin
                if (bits_b.size() == 0) check("b_extra_shcp", 1, 0);
                else check("b_ds", ds_b, bits_b.pop_front());
                sr_b = {sr_b[14:0], ds_b};
                rises_b++;
            end
            if (stcp_b && !prev_st) stor_b = sr_b;
            if (done_b) begin
                if (exp_q_b.size() == 0) check("b_extra_done", 1, 0);
                else check("b_latch", stor_b, exp_q_b.pop_front());
                check("b_shcp_count", rises_b, 16);
                rises_b = 0;
            end
            prev_sh = shcp_b;
            prev_st = stcp_b;
        end
    end

    // Returns at the falling edge of T1 (one cycle after the handshake edge).
    task automatic send_a(input logic [7:0] w);
        int n;
        n = 0;
        while (!in_ready_a && n < 200) begin @(negedge clk); n++; end
        if (!in_ready_a) check("a_ready_timeout", 0, 1);
        in_valid_a = 1'b1;
        in_data_a  = w;
        push_bits({8'h00, w}, 8, 1'b0);
        exp_q_a.push_back(exp_latch({8'h00, w}, 8));
        @(posedge clk);
        @(negedge clk);
        in_valid_a = 1'b0;
        in_data_a  = ~w;
    endtask

    task automatic send_b(input logic [15:0] w);
        int n;
        n = 0;
        while (!in_ready_b && n < 200) begin @(negedge clk); n++; end
        if (!in_ready_b) check("b_ready_timeout", 0, 1);
        in_valid_b = 1'b1;
        in_data_b  = w;
        push_bits(w, 16, 1'b1);
        exp_q_b.push_back(exp_latch(w, 16));
        @(posedge clk);
        @(negedge clk);
        in_valid_b = 1'b0;
        in_data_b  = ~w;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_in_ready"}, in_ready_a, 1);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_ds"}, ds_a, 0);
        check({tag, "_shcp"}, shcp_a, 0);
        check({tag, "_stcp"}, stcp_a, 0);
        check({tag, "_done"}, done_a, 0);
        check({tag, "_oe_n"}, oe_n_a, 1);
        check({tag, "_state"}, st_a, 0);
    endtask

    initial begin
        logic [7:0]  w1;
        logic [15:0] lat;
        int          n;

`ifdef HC595_LSB_FIRST_EN
        w1 = 8'h0F;
`else
        w1 = 8'hA5;
`endif
        repeat (3) @(negedge clk);
        check_reset_a("rst");
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check_reset_a("idle");
        check("b_idle_ready", in_ready_b, 1);
        check("b_idle_oe_n", oe_n_b, 1);

        // Word timing and output-enable release on the first transfer.
        send_a(w1);
        for (int t = 1; t <= 36; t++) begin
            if (t > 1) @(negedge clk);
            check($sformatf("t1_stcp_T%0d", t), stcp_a, (t >= 33 && t <= 34));
            check($sformatf("t1_done_T%0d", t), done_a, (t == 35));
            check($sformatf("t1_ready_T%0d", t), in_ready_a, (t >= 36));
            check($sformatf("t2_oe_n_T%0d", t), oe_n_a, (t <= 35));
        end

        // Held in_valid: second handshake on the first ready cycle; busy-time data ignored.
        send_a(8'h01);
        in_valid_a = 1'b1;
        in_data_a  = 8'h3C;
        for (int t = 1; t <= 36; t++) begin
            if (t > 1) @(negedge clk);
            if (t == 20) in_data_a = 8'h80;
            if (t <= 35) check($sformatf("t3_busy_T%0d", t), in_ready_a, 0);
        end
        check("t3_ready_T36", in_ready_a, 1);
        push_bits(16'h0080, 8, 1'b0);
        exp_q_a.push_back(exp_latch(16'h0080, 8));
        @(negedge clk);
        check("t3_second_taken", in_ready_a, 0);
        in_valid_a = 1'b0;
        for (int t = 2; t <= 36; t++) @(negedge clk);
        check("t3_ready_end", in_ready_a, 1);
        check("t3_oe_n", oe_n_a, 0);

        // Reset in the middle of an all-ones transfer.
        send_a(8'hFF);
        for (int t = 2; t <= 10; t++) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check_reset_a("t4");
        bits_a.delete();
        exp_q_a.delete();
        rises_a = 0;
        repeat (20) @(negedge clk);
        check("t4_storage_kept", stor_a, exp_latch(16'h0080, 8));
        check("t4_oe_n_off", oe_n_a, 1);
        send_a(8'h5A);
        n = 0;
        while (!done_a && n < 100) begin @(negedge clk); n++; end
        check("t4_recover_done", done_a, 1);
        @(negedge clk);
        check("t4_recover_oe_n", oe_n_a, 0);

        // Two-device chain, single-cycle half periods.
        send_b(16'h1234);
        for (int t = 1; t <= 35; t++) begin
            if (t > 1) @(negedge clk);
            check($sformatf("t5_stcp_T%0d", t), stcp_b, (t == 33));
            check($sformatf("t5_done_T%0d", t), done_b, (t == 34));
            check($sformatf("t5_ready_T%0d", t), in_ready_b, (t >= 35));
        end
        lat = exp_latch(16'h1234, 16);
        check("t5_dev2", stor_b[15:8], lat[15:8]);
        check("t5_dev1", stor_b[7:0], lat[7:0]);

        // Random back-to-back words on both instances.
        for (int i = 0; i < 4; i++) begin
            send_b(16'($urandom_range(0, 16'hFFFF)));
            send_a(8'($urandom_range(0, 255)));
        end
        n = 0;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0 || !in_ready_a || !in_ready_b) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_a_words", exp_q_a.size(), 0);
        check("drain_b_words", exp_q_b.size(), 0);
        check("drain_a_bits", bits_a.size(), 0);
        check("drain_b_bits", bits_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
